// File: rtl/rsa_pkg.sv
// Purpose: shared RSA toy-key constants and decryptor state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rsa_pkg;

  localparam int MOD_WIDTH  = 12;
  localparam int EXP_WIDTH  = 12;
  localparam int DATA_WIDTH = 16;

  // Toy key: N = 61 * 53, e = 17, d = 2753 (e*d = 1 mod lcm(60,52)).
  localparam logic [MOD_WIDTH-1:0] MODULUS  = 12'd3233;
  localparam logic [EXP_WIDTH-1:0] PRIV_EXP = 12'd2753;
  localparam logic [4:0]           PUB_EXP  = 5'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SQR,
    ST_MUL,
    ST_FINISH
  } dec_state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Purpose: bit-serial interleaved modular multiply, result = a*b mod MODULUS (a,b < MODULUS).
// Latency: start sampled on edge L, done high in the cycle after edge L+12, result taken on edge L+13 (14 cycles).
// Backpressure: none; a start while running restarts the operation, caller must wait for done.
module rsa_modmul
  import rsa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MOD_WIDTH-1:0] a,
  input  logic [MOD_WIDTH-1:0] b,
  output logic                 done,
  output logic [MOD_WIDTH-1:0] result
);

  // Two guard bits: 2r + b < 3N always fits before folding.
  localparam int RW = MOD_WIDTH + 2;
  localparam logic [RW-1:0] N1 = {2'b00, MODULUS};
  localparam logic [RW-1:0] N2 = {1'b0, MODULUS, 1'b0};

  logic [MOD_WIDTH-1:0] r;
  logic [RW-1:0]        r_sum;
  logic [RW-1:0]        r_next;
  logic [MOD_WIDTH-1:0] a_sh;
  logic [MOD_WIDTH-1:0] b_reg;
  logic [3:0]           cnt;
  logic                 run;
  logic                 wb;
  logic                 unused_hi;

  // One step: double, add b when the current multiplier bit is set, fold back below N.
  always_comb begin
    r_sum  = ({2'b00, r} << 1) + (a_sh[MOD_WIDTH-1] ? {2'b00, b_reg} : '0);
    r_next = r_sum;
    if (r_sum >= N2) begin
      r_next = r_sum - N2;
    end else if (r_sum >= N1) begin
      r_next = r_sum - N1;
    end
  end

  // After folding r_next < N, so its guard bits are always zero.
  assign unused_hi = ^r_next[RW-1:MOD_WIDTH];

  // Load, MOD_WIDTH iterations, then one writeback cycle flagged by wb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= '0;
      a_sh  <= '0;
      b_reg <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      wb    <= 1'b0;
    end else if (start) begin
      r     <= '0;
      a_sh  <= a;
      b_reg <= b;
      cnt   <= 4'(MOD_WIDTH);
      run   <= 1'b1;
      wb    <= 1'b0;
    end else if (run) begin
      r    <= r_next[MOD_WIDTH-1:0];
      a_sh <= a_sh << 1;
      cnt  <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        run <= 1'b0;
        wb  <= 1'b1;
      end
    end else begin
      wb <= 1'b0;
    end
  end

  assign done   = wb;
  assign result = r;

endmodule

// File: rtl/rsa_decryptor.sv
// Purpose: RSA decrypt m = c^d mod N by left-to-right square-and-multiply over rsa_modmul.
// Latency: 240 cycles accept-to-done for valid c, 2 cycles for out-of-range c; fixed, data independent.
// Backpressure: start is only sampled in IDLE; starts while a run is active are dropped.
module rsa_decryptor
  import rsa_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cipher_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] plain_out,
  output logic                  range_err
);

  localparam logic [DATA_WIDTH-1:0] MOD_EXT = {{(DATA_WIDTH-MOD_WIDTH){1'b0}}, MODULUS};

  dec_state_t           state;
  dec_state_t           state_nxt;
  logic [DATA_WIDTH-1:0] c_reg;
  logic [MOD_WIDTH-1:0] acc;
  logic [MOD_WIDTH-1:0] mm_b;
  logic [MOD_WIDTH-1:0] mm_result;
  logic [3:0]           bit_idx;
  logic                 mm_start;
  logic                 mm_done;
  logic                 c_oor;
  logic                 exp_bit;

  assign c_oor   = (c_reg >= MOD_EXT);
  assign exp_bit = PRIV_EXP[bit_idx];
  assign mm_b    = (state == ST_MUL) ? c_reg[MOD_WIDTH-1:0] : acc;

  rsa_modmul u_modmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mm_start),
    .a      (acc),
    .b      (mm_b),
    .done   (mm_done),
    .result (mm_result)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: SQR/MUL advance only when the multiplier reports done.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = c_oor ? ST_FINISH : ST_SQR;
      ST_SQR: begin
        if (mm_done) begin
          if (exp_bit)              state_nxt = ST_MUL;
          else if (bit_idx == 4'd0) state_nxt = ST_FINISH;
          else                      state_nxt = ST_SQR;
        end
      end
      ST_MUL: begin
        if (mm_done) state_nxt = (bit_idx == 4'd0) ? ST_FINISH : ST_SQR;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; mm_start fires on every entry into SQR/MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg     <= '0;
      acc       <= '0;
      bit_idx   <= '0;
      mm_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      plain_out <= '0;
      range_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      mm_start <= ((state_nxt == ST_SQR) || (state_nxt == ST_MUL)) &&
                  ((state == ST_CHECK) || mm_done);
      case (state)
        ST_IDLE: begin
          busy <= start;
          if (start) begin
            c_reg     <= cipher_in;
            range_err <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (c_oor) begin
            plain_out <= '0;
            range_err <= 1'b1;
          end else begin
            acc     <= {{(MOD_WIDTH-1){1'b0}}, 1'b1};
            bit_idx <= 4'(EXP_WIDTH - 1);
          end
        end
        ST_SQR: begin
          if (mm_done) begin
            acc <= mm_result;
            if (!exp_bit && (bit_idx != 4'd0)) bit_idx <= bit_idx - 4'd1;
          end
        end
        ST_MUL: begin
          if (mm_done) begin
            acc <= mm_result;
            if (bit_idx != 4'd0) bit_idx <= bit_idx - 4'd1;
          end
        end
        ST_FINISH: begin
          done <= 1'b1;
          if (!range_err) plain_out <= {{(DATA_WIDTH-MOD_WIDTH){1'b0}}, acc};
        end
        default: ;
      endcase
    end
  end

endmodule
